// File: rtl/csm_pkg.sv
// csm_pkg: shared states, error codes, opcode constants and helpers for call_stack_monitor
package csm_pkg;
  typedef enum logic [1:0] {S_RUN, S_CALL_W2, S_CHK_TGT, S_CHK_RET} state_t;
  typedef enum logic [2:0] {E_NONE, E_OVF, E_UDF, E_TGT, E_RET, E_PROTO} err_t;
  localparam logic [15:0] CALL_MASK  = 16'hFE0E;
  localparam logic [15:0] CALL_MATCH = 16'h940E;
  localparam logic [15:0] ICALL_OP   = 16'h9509;
  localparam logic [15:0] EICALL_OP  = 16'h9519;
  localparam logic [15:0] RET_OP     = 16'h9508;
  localparam logic [15:0] RETI_OP    = 16'h9518;
  localparam logic [3:0]  RCALL_HI   = 4'hD;
  function automatic logic [21:0] sext12(input logic [11:0] k);
    return {{10{k[11]}}, k};
  endfunction
endpackage

// File: rtl/csm_lifo.sv
// csm_lifo: register stack; a pop reads the old top, then up to two pushes land in order
module csm_lifo #(
  parameter int W = 16,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  input  logic          i_clr,
  input  logic          i_pop,
  input  logic          i_push_a,
  input  logic [W-1:0]  i_data_a,
  input  logic          i_push_b,
  input  logic [W-1:0]  i_data_b,
  output logic [W-1:0]  o_top,
  output logic [CW-1:0] o_cnt,
  output logic [CW-1:0] o_cnt_nxt,
  output logic          o_ovf_a,
  output logic          o_ovf_b
);
  logic [W-1:0]  r_mem [DEPTH];
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_c1;
  logic [CW-1:0] w_c2;
  logic          w_wa;
  logic          w_wb;
  always_comb begin
    w_c1      = r_cnt - CW'(i_pop && r_cnt != '0);
    w_wa      = i_push_a && w_c1 != CW'(DEPTH);
    w_c2      = w_c1 + CW'(w_wa);
    w_wb      = i_push_b && w_c2 != CW'(DEPTH);
    o_cnt_nxt = w_c2 + CW'(w_wb);
    o_ovf_a   = i_push_a && !w_wa;
    o_ovf_b   = i_push_b && !w_wb;
    o_top     = r_mem[AW'(r_cnt - CW'(1))];
    o_cnt     = r_cnt;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else if (i_en) r_cnt <= i_clr ? '0 : o_cnt_nxt;
  always_ff @(posedge clk)
    if (i_en && !i_clr) begin
      if (w_wa) r_mem[w_c1[AW-1:0]] <= i_data_a;
      if (w_wb) r_mem[w_c2[AW-1:0]] <= i_data_b;
    end
endmodule

// File: rtl/call_stack_monitor.sv
// call_stack_monitor: shadow return-address stack checking calls and returns of the retired stream
module call_stack_monitor
  import csm_pkg::*;
#(
  parameter int PC_W = 16,
  parameter int DEPTH = 16,
  parameter int CNT_W = 16,
  localparam int DW = $clog2(DEPTH) + 1
) (
  input  logic             cp2,
  input  logic             ireset,
  input  logic             cp2en,
  input  logic             clear,
  input  logic             fetch_valid,
  input  logic [PC_W-1:0]  fetch_pc,
  input  logic [15:0]      fetch_instr,
  input  logic             irq_entry,
  input  logic [PC_W-1:0]  irq_ret_pc,
  output logic [DW-1:0]    depth,
  output logic [DW-1:0]    max_depth,
  output logic [CNT_W-1:0] call_cnt,
  output logic [CNT_W-1:0] ret_cnt,
  output logic             err,
  output logic [2:0]       err_code,
  output logic [PC_W-1:0]  err_pc
);
  state_t          r_state;
  logic [PC_W-1:0] r_exp;
  logic [PC_W-1:0] r_ret;
  logic [PC_W-1:0] r_pc;
  logic [5:0]      r_hi;
  logic            w_w2, w_dec, w_call, w_rcall, w_icall, w_ret, w_pop, w_udf, w_push_a;
  logic            w_bad_seq, w_bad_chk, w_ovf_a, w_ovf_b;
  logic [PC_W-1:0] w_pc1, w_data_a, w_top, w_rtgt;
  logic [DW-1:0]   w_cnt_nxt;
  logic [CNT_W:0]  w_cc_sum, w_rc_sum;
  err_t            w_err;
  always_comb begin
    w_w2      = fetch_valid && r_state == S_CALL_W2;
    w_dec     = fetch_valid && r_state != S_CALL_W2;
    w_call    = w_dec && (fetch_instr & CALL_MASK) == CALL_MATCH;
    w_rcall   = w_dec && fetch_instr[15:12] == RCALL_HI;
    w_icall   = w_dec && (fetch_instr == ICALL_OP || fetch_instr == EICALL_OP);
    w_ret     = w_dec && (fetch_instr == RET_OP || fetch_instr == RETI_OP);
    w_udf     = w_ret && depth == '0;
    w_pop     = w_ret && !w_udf;
    w_pc1     = fetch_pc + PC_W'(1);
    w_rtgt    = w_pc1 + PC_W'(sext12(fetch_instr[11:0]));
    w_push_a  = w_w2 || w_rcall || w_icall;
    w_data_a  = w_w2 ? r_ret : w_pc1;
    w_bad_seq = w_w2 && fetch_pc != r_pc + PC_W'(1);
    w_bad_chk = w_dec && r_state != S_RUN && fetch_pc != r_exp;
    w_err     = w_bad_seq ? E_PROTO :
                w_bad_chk ? (r_state == S_CHK_TGT ? E_TGT : E_RET) :
                w_udf ? E_UDF :
                (w_ovf_a || w_ovf_b) ? E_OVF : E_NONE;
    w_cc_sum  = {1'b0, call_cnt} + (CNT_W+1)'(w_push_a) + (CNT_W+1)'(irq_entry);
    w_rc_sum  = {1'b0, ret_cnt} + (CNT_W+1)'(w_ret);
  end
  csm_lifo #(.W(PC_W), .DEPTH(DEPTH)) u_lifo (
    .clk(cp2), .rst(ireset), .i_en(cp2en), .i_clr(clear),
    .i_pop(w_pop), .i_push_a(w_push_a), .i_data_a(w_data_a),
    .i_push_b(irq_entry), .i_data_b(irq_ret_pc),
    .o_top(w_top), .o_cnt(depth), .o_cnt_nxt(w_cnt_nxt),
    .o_ovf_a(w_ovf_a), .o_ovf_b(w_ovf_b)
  );
  always_ff @(posedge cp2 or posedge ireset)
    if (ireset) begin
      r_state <= S_RUN; r_exp <= '0; r_ret <= '0; r_pc <= '0; r_hi <= '0;
      max_depth <= '0; call_cnt <= '0; ret_cnt <= '0; err <= 1'b0; err_code <= '0; err_pc <= '0;
    end else if (cp2en) begin
      if (clear) begin
        r_state <= S_RUN; r_exp <= '0; r_ret <= '0; r_pc <= '0; r_hi <= '0;
        max_depth <= '0; call_cnt <= '0; ret_cnt <= '0; err <= 1'b0; err_code <= '0; err_pc <= '0;
      end else begin
        if (w_w2) begin
          r_state <= S_CHK_TGT;
          r_exp   <= PC_W'({r_hi, fetch_instr});
        end else if (w_dec) begin
          r_state <= w_call ? S_CALL_W2 : w_rcall ? S_CHK_TGT : w_pop ? S_CHK_RET : S_RUN;
          r_exp   <= w_rcall ? w_rtgt : w_pop ? w_top : r_exp;
          if (w_call) begin
            r_ret <= fetch_pc + PC_W'(2);
            r_pc  <= fetch_pc;
            r_hi  <= {fetch_instr[8:4], fetch_instr[0]};
          end
        end
        call_cnt  <= w_cc_sum[CNT_W] ? '1 : w_cc_sum[CNT_W-1:0];
        ret_cnt   <= w_rc_sum[CNT_W] ? '1 : w_rc_sum[CNT_W-1:0];
        max_depth <= w_cnt_nxt > max_depth ? w_cnt_nxt : max_depth;
        if (!err && w_err != E_NONE) begin
          err      <= 1'b1;
          err_code <= w_err;
          err_pc   <= fetch_pc;
        end
      end
    end
endmodule

// File: doc/call_stack_monitor.md
Name: call_stack_monitor

Overview:
Synthesizable, parametrised successor to the fixed-length CALL testbench checks for the ATmega328PB core. It observes the core's retired-instruction stream and keeps a shadow return-address stack, pushing on CALL/RCALL/ICALL/EICALL and on interrupt entry, and popping on RET/RETI. It checks call targets and return targets, counts events, and latches the first error. It sits beside the core in design_1 and also serves as a bench monitor, replacing the hand-coded per-test comparisons.

Parameters:
PC_W, 16, program-counter width in words (16 = 328PB, up to 22 for EICALL parts)
DEPTH, 16, shadow-stack entries (power of two, 2..64)
CNT_W, 16, width of the call/return event counters

Ports:
cp2  in  1  core clock
ireset  in  1  asynchronous reset, active-high
cp2en  in  1  clock enable; no state changes when 0
clear  in  1  synchronous clear of stack, counters and error (same effect as reset)
fetch_valid  in  1  one pulse per executed instruction word (including CALL second word)
fetch_pc  in  PC_W  word address of fetch_instr
fetch_instr  in  16  instruction word
irq_entry  in  1  pulse: interrupt accepted; irq_ret_pc is pushed
irq_ret_pc  in  PC_W  return address for the interrupt
depth  out  $clog2(DEPTH)+1  current stack occupancy
max_depth  out  $clog2(DEPTH)+1  high-water mark
call_cnt  out  CNT_W  pushes (calls + interrupts), saturating
ret_cnt  out  CNT_W  pops, saturating
err  out  1  sticky error flag
err_code  out  3  first error: 0 none, 1 overflow, 2 underflow, 3 bad call target, 4 bad return target, 5 protocol
err_pc  out  PC_W  fetch_pc at which the first error was detected

Behaviour:
- Reset/clear: all outputs 0, stack empty, FSM = S_RUN. Reset takes effect mid-operation with no ordering dependence.
- All updates occur on the rising edge of cp2 with cp2en=1; outputs are registered, with one-cycle latency from the triggering fetch.
- Decode, on fetch_valid in S_RUN:
  - CALL (mask 0xFE0E, match 0x940E): goto S_CALL_W2 with ret = pc+2.
  - RCALL (0xDxxx): push pc+1; exp = pc+1+sext(k12), truncated to PC_W; goto S_CHK_TGT.
  - ICALL 0x9509 / EICALL 0x9519: push pc+1; target not checked.
  - RET 0x9508 / RETI 0x9518: pop to exp; goto S_CHK_RET.
  - Anything else: no action.
- S_CALL_W2: the next fetch_valid must have fetch_pc = previous pc+1, else error 5. k22 = {first[8:4], first[0], word2}; exp = k22 truncated to PC_W. Push ret, then goto S_CHK_TGT.
- S_CHK_TGT / S_CHK_RET: the next fetch_valid compares fetch_pc with exp; a mismatch gives error 3 or 4. The instruction at that fetch is then decoded as in S_RUN in the same cycle, so a CALL landing on a RET is legal.
- Push with depth == DEPTH: error 1; the push is dropped and depth is unchanged.
- Pop with depth == 0: error 2; no compare and no target check; return to S_RUN.
- irq_entry: pushes irq_ret_pc in any state, with overflow rules as above.
  - irq_entry with a same-cycle pop: the pop reads the top first, then the push writes, so depth is unchanged.
  - irq_entry with a same-cycle push: the instruction push goes first, then the irq push; depth +2, with an overflow check per push.
- Errors: only the first error sets err_code/err_pc; later errors are ignored until clear. The monitor keeps tracking after an error.
- Counters saturate at all-ones. max_depth updates whenever depth exceeds it.
- fetch_valid=0: state holds. cp2en=0: everything freezes, including irq_entry.

Decomposition:
- Package csm_pkg holds: the state enum (S_RUN, S_CALL_W2, S_CHK_TGT, S_CHK_RET), the err_code enum, the opcode masks/match constants, and function sext12.
- One sub-module, csm_lifo (DEPTH x PC_W register stack with push/pop/full/empty and simultaneous pop-then-push), instantiated once.

Test Plan:
- CALL 0x940E,0x0100 at pc 0x0010 -> push 0x0012, next fetch 0x0100 ok; RET there -> next fetch 0x0012 ok; depth 1->0, call_cnt=1, ret_cnt=1, err=0.
- RCALL 0xDFFF at pc 0x0020 (k=-1) -> exp 0x0020; a fetch at 0x0021 instead -> err=1, err_code=3, err_pc=0x0021.
- 17 nested RCALLs with DEPTH=16 -> err_code=1 on the 17th, depth=16, max_depth=16.
- RET with empty stack at pc 0x0005 -> err_code=2, err_pc=0x0005, depth stays 0.
- irq_entry (irq_ret_pc=0x0033) in the same cycle as a RET fetch, stack top 0x0044 -> RET checks 0x0044, 0x0033 is left on top, depth unchanged.
- Assert ireset while in S_CALL_W2 -> all outputs 0 immediately; the next CALL word 2 is decoded as a plain instruction.
